// File: rtl/cpu6_pkg.sv
// CPU6 shared definitions: datapath width, RV32I opcode and
// funct constants, and the ALU operation encoding.
package cpu6_pkg;

    localparam int CPU6_XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_PASSB
    } alu_op_e;

endpackage

// File: rtl/cpu6_regfile.sv
// CPU6 register file: 32 x XLEN, two combinational read ports,
// one write port, async active-low clear, x0 hardwired to zero.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i (write),
//        raddr1_i/rdata1_o, raddr2_i/rdata2_o (reads).
module cpu6_regfile
    import cpu6_pkg::*;
#(
    parameter int XLEN = CPU6_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/cpu6_top.sv
// CPU6 top: single-cycle RV32I-subset core with instruction ROM
// and data RAM. Ports: clk, reset (async, active-low). No outputs.
// Optional macro CPU6_TRACE_EN adds a per-retire $display trace.
module cpu6_top
    import cpu6_pkg::*;
#(
    parameter int XLEN       = CPU6_XLEN,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter     IMEM_INIT  = "program.hex"
) (
    input logic clk,
    input logic reset
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     insn;

    assign insn     = imem[pc_q[IAW+1:2]];
    assign pc_plus4 = pc_q + XLEN'(4);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign f7     = insn[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = XLEN'($signed(insn[31:20]));
    assign imm_s = XLEN'($signed({insn[31:25], insn[11:7]}));
    assign imm_b = XLEN'($signed({insn[31], insn[7],
                                  insn[30:25], insn[11:8],
                                  1'b0}));
    assign imm_u = XLEN'($signed({insn[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({insn[31], insn[19:12],
                                  insn[20], insn[30:21],
                                  1'b0}));

    logic [XLEN-1:0] rs1_v, rs2_v;
    logic [XLEN-1:0] wb_data;
    logic            rd_we;

    cpu6_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset),
        .we_i     (rd_we),
        .waddr_i  (rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .rdata1_o (rs1_v),
        .raddr2_i (rs2),
        .rdata2_o (rs2_v)
    );

    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b;
    logic            mem_we;
    logic            is_load;
    logic            is_jal;
    logic            br_taken;

    // Unlisted opcode/funct combos fall through with every
    // enable low, which makes them NOPs.
    always_comb begin
        alu_op   = ALU_ADD;
        alu_b    = imm_i;
        rd_we    = 1'b0;
        mem_we   = 1'b0;
        is_load  = 1'b0;
        is_jal   = 1'b0;
        br_taken = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu_op = ALU_PASSB;
                alu_b  = imm_u;
                rd_we  = 1'b1;
            end
            OP_IMM: begin
                case (f3)
                    F3_ADD: rd_we = 1'b1;
                    F3_AND: begin
                        alu_op = ALU_AND;
                        rd_we  = 1'b1;
                    end
                    F3_OR: begin
                        alu_op = ALU_OR;
                        rd_we  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                alu_b = rs2_v;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD: rd_we = 1'b1;
                        F3_AND: begin
                            alu_op = ALU_AND;
                            rd_we  = 1'b1;
                        end
                        F3_OR: begin
                            alu_op = ALU_OR;
                            rd_we  = 1'b1;
                        end
                        F3_SLT: begin
                            alu_op = ALU_SLT;
                            rd_we  = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (f7 == F7_SUB && f3 == F3_ADD) begin
                    alu_op = ALU_SUB;
                    rd_we  = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 == F3_LW) begin
                    rd_we   = 1'b1;
                    is_load = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == F3_SW) begin
                    alu_b  = imm_s;
                    mem_we = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (f3)
                    F3_BEQ: br_taken = (rs1_v == rs2_v);
                    F3_BNE: br_taken = (rs1_v != rs2_v);
                    default: ;
                endcase
            end
            OP_JAL: begin
                rd_we  = 1'b1;
                is_jal = 1'b1;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] alu_y;

    always_comb begin
        alu_y = rs1_v + alu_b;
        case (alu_op)
            ALU_SUB:   alu_y = rs1_v - alu_b;
            ALU_AND:   alu_y = rs1_v & alu_b;
            ALU_OR:    alu_y = rs1_v | alu_b;
            ALU_SLT:   alu_y = {{(XLEN-1){1'b0}},
                                $signed(rs1_v) < $signed(alu_b)};
            ALU_PASSB: alu_y = alu_b;
            default:   ;
        endcase
    end

    logic [DAW-1:0]  dmem_idx;
    logic [XLEN-1:0] dmem_rdata;

    // Byte offset bits are dropped; upper bits wrap by index width.
    assign dmem_idx   = alu_y[DAW+1:2];
    assign dmem_rdata = dmem[dmem_idx];

    // RAM has no reset so contents survive; reset only gates writes.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            dmem[dmem_idx] <= rs2_v;
        end
    end

    assign wb_data = is_load ? dmem_rdata :
                     is_jal  ? pc_plus4   : alu_y;

    assign pc_d = is_jal   ? pc_q + imm_j :
                  br_taken ? pc_q + imm_b : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef CPU6_TRACE_EN
    always @(posedge clk) begin
        if (reset) begin
            if (rd_we && rd != 5'd0) begin
                $display("pc=%h insn=%h x%0d=%h",
                         pc_q, insn, rd, wb_data);
            end else if (mem_we) begin
                $display("pc=%h insn=%h [%h]=%h",
                         pc_q, insn, alu_y, rs2_v);
            end else begin
                $display("pc=%h insn=%h", pc_q, insn);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu6_top.sv
// Bench for cpu6_top: directed vector tables plus random programs
// checked against an instruction-level reference model.
module tb_cpu6_top;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    cpu6_top dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef enum int {K_PC, K_REG, K_MEM} kind_e;

    typedef struct {
        int          steps;
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } vec_t;

    int nchk = 0;
    int nerr = 0;
    int nsteps = 0;

    logic [31:0] prog  [256];
    logic [31:0] m_pc;
    logic [31:0] m_x   [32];
    logic [31:0] m_mem [256];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                          int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0],
                7'h33};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                          int rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0],
                7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1,
                                          int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0],
                7'h6f};
    endfunction

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] probe(kind_e k, int idx);
        case (k)
            K_PC:    return dut.pc_q;
            K_REG:   return dut.u_regfile.regs_q[idx[4:0]];
            default: return dut.dmem[idx[7:0]];
        endcase
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_x[i] = 0;
    endtask

    // Architectural behaviour of one instruction.
    task automatic model_step();
        logic [31:0] ins, a, b, ii, val, nxt, ea;
        int op, rd, f3, f7;
        bit wr;
        ins = prog[(m_pc >> 2) % 256];
        op  = int'(ins[6:0]);
        rd  = int'(ins[11:7]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = 32'($signed(ins[31:20]));
        nxt = m_pc + 4;
        wr  = 0;
        val = 0;
        case (op)
            'h37: begin wr = 1; val = {ins[31:12], 12'h000}; end
            'h13: begin
                wr = 1;
                if (f3 == 0) val = a + ii;
                else if (f3 == 7) val = a & ii;
                else if (f3 == 6) val = a | ii;
                else wr = 0;
            end
            'h33: begin
                wr = 1;
                if (f7 == 0 && f3 == 0) val = a + b;
                else if (f7 == 'h20 && f3 == 0) val = a - b;
                else if (f7 == 0 && f3 == 7) val = a & b;
                else if (f7 == 0 && f3 == 6) val = a | b;
                else if (f7 == 0 && f3 == 2)
                    val = ($signed(a) < $signed(b)) ? 1 : 0;
                else wr = 0;
            end
            'h03: if (f3 == 2) begin
                wr = 1;
                val = m_mem[((a + ii) >> 2) % 256];
            end
            'h23: if (f3 == 2) begin
                ea = a + 32'($signed({ins[31:25], ins[11:7]}));
                m_mem[(ea >> 2) % 256] = b;
            end
            'h63: begin
                if ((f3 == 0 && a == b) || (f3 == 1 && a != b))
                    nxt = m_pc + 32'($signed({ins[31], ins[7],
                          ins[30:25], ins[11:8], 1'b0}));
            end
            'h6f: begin
                wr = 1;
                val = m_pc + 4;
                nxt = m_pc + 32'($signed({ins[31], ins[19:12],
                      ins[20], ins[30:21], 1'b0}));
            end
            default: ;
        endcase
        if (wr && rd != 0) m_x[rd] = val;
        m_pc = nxt;
    endtask

    task automatic check_state(string tag);
        chk({tag, "_pc"}, dut.pc_q, m_pc);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_x%0d", tag, i),
                dut.u_regfile.regs_q[i], m_x[i]);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        #1;
        model_step();
        nsteps++;
        check_state(tag);
    endtask

    task automatic run_table(input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            while (nsteps < t[i].steps) step("dir");
            chk(t[i].name, probe(t[i].kind, t[i].idx), t[i].exp);
        end
    endtask

    // Called at edge+1: assert reset 3 ns after the edge, check the
    // immediate clear, hold reset over one edge.
    task automatic mid_reset(string tag);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_pc"}, dut.pc_q, 32'h0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_x%0d", tag, i),
                dut.u_regfile.regs_q[i], 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        chk({tag, "_hold_pc"}, dut.pc_q, 32'h0);
        for (int i = 0; i < 256; i++)
            chk($sformatf("%s_mem%0d", tag, i), dut.dmem[i], m_mem[i]);
    endtask

    function automatic logic [31:0] rand_insn();
        int sel, rd, r1, r2, imm, off;
        sel = int'($urandom_range(0, 15));
        rd  = int'($urandom_range(0, 7));
        r1  = int'($urandom_range(0, 7));
        r2  = int'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 4095)) - 2048;
        off = (int'($urandom_range(0, 15)) - 4) * 4;
        if (off == 0) off = 8;
        case (sel)
            0:       return enc_u(int'($urandom), rd);
            1, 2:    return enc_i(imm, r1, 0, rd, 7'h13);
            3:       return enc_i(imm, r1, 7, rd, 7'h13);
            4:       return enc_i(imm, r1, 6, rd, 7'h13);
            5:       return enc_r(0, r2, r1, 0, rd);
            6:       return enc_r('h20, r2, r1, 0, rd);
            7:       return enc_r(0, r2, r1, 7, rd);
            8:       return enc_r(0, r2, r1, 6, rd);
            9:       return enc_r(0, r2, r1, 2, rd);
            10:      return enc_i(imm, r1, 2, rd, 7'h03);
            11, 12:  return enc_s(imm, r2, r1);
            13:      return enc_b(off, r2, r1, sel & 1);
            14:      return enc_j(off, rd);
            default: return $urandom;
        endcase
    endfunction

    vec_t tab1[$];
    vec_t tab2[$];

    initial begin
        tab1.push_back('{4,  K_REG, 3,  32'd12,        "add_x3"});
        tab1.push_back('{4,  K_REG, 4,  32'd2,         "sub_x4"});
        tab1.push_back('{5,  K_REG, 0,  32'd0,         "x0_const"});
        tab1.push_back('{6,  K_MEM, 21, 32'd12,        "sw_mem21"});
        tab1.push_back('{7,  K_REG, 5,  32'd12,        "lw_x5"});
        tab1.push_back('{8,  K_REG, 6,  32'd12,        "lw_lowbits"});
        tab1.push_back('{9,  K_PC,  0,  32'h28,        "beq_taken"});
        tab1.push_back('{10, K_PC,  0,  32'h2C,        "bne_fall"});
        tab1.push_back('{11, K_REG, 7,  32'd1,         "slt_x7"});
        tab1.push_back('{12, K_REG, 8,  32'h1234_5000, "lui_x8"});
        tab1.push_back('{13, K_PC,  0,  32'h38,        "undef_pc"});
        tab1.push_back('{13, K_REG, 10, 32'd0,         "skip_x10"});
        tab1.push_back('{14, K_REG, 9,  32'h3C,        "jal_link"});
        tab1.push_back('{14, K_PC,  0,  32'h34,        "jal_back"});
        tab2.push_back('{9,  K_PC,  0,  32'h1C,        "jal20_pc"});
        tab2.push_back('{9,  K_REG, 9,  32'h24,        "jal20_x9"});

        for (int i = 0; i < 256; i++) prog[i] = NOP;
        prog[0]  = enc_i(5, 0, 0, 1, 7'h13);
        prog[1]  = enc_i(7, 0, 0, 2, 7'h13);
        prog[2]  = enc_r(0, 2, 1, 0, 3);
        prog[3]  = enc_r('h20, 1, 2, 0, 4);
        prog[4]  = enc_i(9, 0, 0, 0, 7'h13);
        prog[5]  = enc_s(84, 3, 0);
        prog[6]  = enc_i(84, 0, 2, 5, 7'h03);
        prog[7]  = enc_i(85, 0, 2, 6, 7'h03);
        prog[8]  = enc_b(8, 1, 1, 0);
        prog[9]  = enc_i(1, 0, 0, 10, 7'h13);
        prog[10] = enc_b(8, 1, 1, 1);
        prog[11] = enc_r(0, 1, 4, 2, 7);
        prog[12] = enc_u('h12345, 8);
        prog[13] = 32'hFFFF_FFFF;
        prog[14] = enc_j(-4, 9);

        #1;
        for (int i = 0; i < 256; i++) begin
            dut.dmem[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        load_prog();
        model_reset();

        #5 chk("rst_pc_t6", dut.pc_q, 32'h0);
        #10 chk("rst_pc_t16", dut.pc_q, 32'h0);
        #6 reset = 1'b1;
        step("p1");
        chk("first_pc", dut.pc_q, 32'h4);
        run_table(tab1);

        mid_reset("midrst");
        chk("midrst_mem21", dut.dmem[21], 32'd12);

        for (int i = 0; i < 256; i++) prog[i] = NOP;
        prog[8] = enc_j(-4, 9);
        load_prog();
        #1 reset = 1'b1;
        nsteps = 0;
        run_table(tab2);

        for (int r = 0; r < 4; r++) begin
            mid_reset($sformatf("rrst%0d", r));
            for (int i = 0; i < 256; i++) prog[i] = rand_insn();
            load_prog();
            #1 reset = 1'b1;
            for (int s = 0; s < 150; s++) step($sformatf("rnd%0d", r));
        end
        for (int i = 0; i < 256; i++)
            chk($sformatf("final_mem%0d", i), dut.dmem[i], m_mem[i]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
